// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and baud/oversampling helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int baud_div(input int clock_input, input int baudrate, input int oversampling);
        return clock_input / (baudrate * oversampling);
    endfunction

    function automatic int mid_sample(input int oversampling);
        return oversampling / 2;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, restartable by clear_i.
module uart_rx_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronised, oversampled line with 3-sample majority vote,
// valid/ready byte output, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BYTESIZES    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int BAUDRATE     = 115200,
    parameter int CLOCK_INPUT  = 50_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sdata_rx_in,
    input  logic                 ready_rx_in,
    output logic [BYTESIZES-1:0] data_rx_out,
    output logic                 valid_rx_out,
    output logic                 frame_error_out,
    output logic                 overrun_out
);

    localparam int DIV = baud_div(CLOCK_INPUT, BAUDRATE, OVERSAMPLING);
    localparam int MID = mid_sample(OVERSAMPLING);
    localparam int SW  = $clog2(OVERSAMPLING);
    localparam int BW  = (BYTESIZES > 1) ? $clog2(BYTESIZES) : 1;

    if (DIV < 1) begin : g_div_chk
        $error("uart_rx: clock too slow for BAUDRATE*OVERSAMPLING");
    end
    if ((OVERSAMPLING % 2) != 0 || OVERSAMPLING < 4) begin : g_os_chk
        $error("uart_rx: OVERSAMPLING must be even and at least 4");
    end

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 tick, start_det;
    logic [SW-1:0]        s_q, s_nxt;
    logic                 samp_lo, samp_mid, decide, vote;
    logic [1:0]           v_q;
    rx_state_t            state_q, state_d;
    logic [BYTESIZES-1:0] shift_q, shift_d, data_q, data_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sdata_rx_in};
        end
    end

    assign rx_s      = sync_q[1];
    assign start_det = (state_q == IDLE) && !rx_s;

    uart_rx_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clock   (clock),
        .reset   (reset),
        .clear_i (start_det),
        .tick_o  (tick)
    );

    // Samples are keyed on the value s takes at this tick, so tick k after detect sees s = k mod OVERSAMPLING.
    assign s_nxt    = (s_q == SW'(OVERSAMPLING - 1)) ? '0 : s_q + 1'b1;
    assign samp_lo  = tick && (s_nxt == SW'(MID - 1));
    assign samp_mid = tick && (s_nxt == SW'(MID));
    assign decide   = tick && (s_nxt == SW'(MID + 1));
    assign vote     = majority3(v_q[0], v_q[1], rx_s);

    always_ff @(posedge clock) begin
        if (reset || start_det) begin
            s_q <= '0;
        end else if (tick) begin
            s_q <= s_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_q <= '0;
        end else begin
            if (samp_lo)  v_q[0] <= rx_s;
            if (samp_mid) v_q[1] <= rx_s;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = valid_q & ~ready_rx_in;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                // Moving to DATA here is equivalent to waiting for the boundary: DATA only acts on the next window's decision.
                if (decide) begin
                    state_d = vote ? IDLE : DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[BYTESIZES-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(BYTESIZES - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (vote) begin
                        if (!valid_q || ready_rx_in) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_rx_out     = data_q;
    assign valid_rx_out    = valid_q;
    assign frame_error_out = ferr_q;
    assign overrun_out     = ovr_q;

endmodule
